// File: rtl/swt16_pkg.sv
// ============================================================================
//  Module      : swt16_pkg
//  Description : Shared constants for the hazard controller (forward-select
//                encoding and tracker entry field widths).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package swt16_pkg;

    localparam int FWD_REGFILE   = 0;
    localparam int ENTRY_VALID_W = 1;
    localparam int ENTRY_LOAD_W  = 1;

    // Full entry width once the register index width is known.
    function automatic int entry_width(input int idx_w);
        return ENTRY_VALID_W + idx_w + ENTRY_LOAD_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// ============================================================================
//  Module      : hazard_match
//  Description : Youngest-match search of one DC source against the tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_match
    import swt16_pkg::*;
#(
    parameter int REG_IDX_WIDTH = 4,
    parameter int PIPE_DEPTH    = 3,
    parameter int SEL_WIDTH     = 2
) (
    input  logic [REG_IDX_WIDTH-1:0]            src_idx,
    input  logic                                src_used,
    input  logic [PIPE_DEPTH-1:0]               entry_valid,
    input  logic [PIPE_DEPTH*REG_IDX_WIDTH-1:0] entry_idx,
    input  logic [PIPE_DEPTH-1:0]               entry_load,
    output logic                                hit,
    output logic [SEL_WIDTH-1:0]                sel,
    output logic                                hit_load
);

    // Scan oldest to youngest so the lowest matching stage wins.
    always_comb begin
        hit      = 1'b0;
        sel      = SEL_WIDTH'(FWD_REGFILE);
        hit_load = 1'b0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (src_used && entry_valid[k] &&
                entry_idx[k*REG_IDX_WIDTH +: REG_IDX_WIDTH] == src_idx) begin
                hit      = 1'b1;
                sel      = SEL_WIDTH'(k + 1);
                hit_load = entry_load[k];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard detection, stall generation and forwarding
//                select; HAZARD_FORWARDING_EN enables operand forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import swt16_pkg::*;
#(
    parameter  int REG_IDX_WIDTH = 4,
    parameter  int PIPE_DEPTH    = 3,
    parameter  int CNT_WIDTH     = 16,
    localparam int SEL_WIDTH     = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_dc_valid,
    input  logic [REG_IDX_WIDTH-1:0] in_src1_idx,
    input  logic [REG_IDX_WIDTH-1:0] in_src2_idx,
    input  logic                     in_src1_used,
    input  logic                     in_src2_used,
    input  logic [REG_IDX_WIDTH-1:0] in_dst_idx,
    input  logic                     in_dst_write,
    input  logic                     in_dst_is_load,
    input  logic                     in_flush,
    input  logic                     in_count_clr,
    output logic                     out_stall,
    output logic [SEL_WIDTH-1:0]     out_fwd_src1_sel,
    output logic [SEL_WIDTH-1:0]     out_fwd_src2_sel,
    output logic [CNT_WIDTH-1:0]     out_stall_count
);

    logic [PIPE_DEPTH-1:0]               ent_valid;
    logic [PIPE_DEPTH-1:0]               ent_load;
    logic [PIPE_DEPTH*REG_IDX_WIDTH-1:0] ent_idx;
    logic                                hit1, hit2, load1, load2;
    logic [SEL_WIDTH-1:0]                sel1, sel2;
    logic                                stall;
    logic                                insert;
    logic [CNT_WIDTH-1:0]                count;

    hazard_match #(
        .REG_IDX_WIDTH(REG_IDX_WIDTH), .PIPE_DEPTH(PIPE_DEPTH), .SEL_WIDTH(SEL_WIDTH)
    ) u_match_src1 (
        .src_idx(in_src1_idx), .src_used(in_src1_used),
        .entry_valid(ent_valid), .entry_idx(ent_idx), .entry_load(ent_load),
        .hit(hit1), .sel(sel1), .hit_load(load1)
    );

    hazard_match #(
        .REG_IDX_WIDTH(REG_IDX_WIDTH), .PIPE_DEPTH(PIPE_DEPTH), .SEL_WIDTH(SEL_WIDTH)
    ) u_match_src2 (
        .src_idx(in_src2_idx), .src_used(in_src2_used),
        .entry_valid(ent_valid), .entry_idx(ent_idx), .entry_load(ent_load),
        .hit(hit2), .sel(sel2), .hit_load(load2)
    );

`ifdef HAZARD_FORWARDING_EN
    localparam logic [SEL_WIDTH-1:0] SEL_EX = SEL_WIDTH'(1);
    logic unused_hits;
    assign unused_hits = hit1 ^ hit2;

    // Only a load sitting in EX cannot be forwarded in time.
    always_comb begin
        stall            = 1'b0;
        out_fwd_src1_sel = SEL_WIDTH'(FWD_REGFILE);
        out_fwd_src2_sel = SEL_WIDTH'(FWD_REGFILE);
        if (!in_flush) begin
            out_fwd_src1_sel = sel1;
            out_fwd_src2_sel = sel2;
            stall = in_dc_valid && ((sel1 == SEL_EX && load1) ||
                                    (sel2 == SEL_EX && load2));
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{sel1, sel2, load1, load2};

    always_comb begin
        stall            = in_dc_valid && !in_flush && (hit1 || hit2);
        out_fwd_src1_sel = SEL_WIDTH'(FWD_REGFILE);
        out_fwd_src2_sel = SEL_WIDTH'(FWD_REGFILE);
    end
`endif

    assign insert          = in_dc_valid && in_dst_write && !stall && !in_flush;
    assign out_stall       = stall;
    assign out_stall_count = count;

    // A stalled or flushed DC instruction enters EX as a bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ent_valid <= '0;
            ent_load  <= '0;
            ent_idx   <= '0;
        end else begin
            ent_valid <= {ent_valid[PIPE_DEPTH-2:0], insert};
            ent_load  <= {ent_load[PIPE_DEPTH-2:0], in_dst_is_load};
            ent_idx   <= {ent_idx[(PIPE_DEPTH-1)*REG_IDX_WIDTH-1:0], in_dst_idx};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (in_count_clr) begin
            count <= '0;
        end else if (stall && count != {CNT_WIDTH{1'b1}}) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed vector bench for hazard_ctrl (PIPE_DEPTH=3,
//                CNT_WIDTH=4); expectations follow HAZARD_FORWARDING_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int NVEC = 20;
    localparam int CNT_AFTER_TABLE = FWD ? 1 : 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       dc_valid, src1_used, src2_used, dst_write, dst_is_load, flush, count_clr;
    logic [3:0] src1_idx, src2_idx, dst_idx;
    logic       stall;
    logic [1:0] sel1, sel2;
    logic [3:0] cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    hazard_ctrl #(.REG_IDX_WIDTH(4), .PIPE_DEPTH(3), .CNT_WIDTH(4)) dut (
        .clock(clock), .reset(reset),
        .in_dc_valid(dc_valid),
        .in_src1_idx(src1_idx), .in_src2_idx(src2_idx),
        .in_src1_used(src1_used), .in_src2_used(src2_used),
        .in_dst_idx(dst_idx), .in_dst_write(dst_write), .in_dst_is_load(dst_is_load),
        .in_flush(flush), .in_count_clr(count_clr),
        .out_stall(stall),
        .out_fwd_src1_sel(sel1), .out_fwd_src2_sel(sel2),
        .out_stall_count(cnt)
    );

    typedef struct {
        logic       dv;
        logic [3:0] s1;
        logic       u1;
        logic [3:0] s2;
        logic       u2;
        logic [3:0] dst;
        logic       wr;
        logic       ld;
        logic       ex_stall;
        logic [1:0] ex_s1;
        logic [1:0] ex_s2;
        logic [3:0] ex_cnt;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic dv, input logic [3:0] s1, input logic u1,
                                input logic [3:0] s2, input logic u2,
                                input logic [3:0] dst, input logic wr, input logic ld,
                                input logic nst, input int ncnt,
                                input logic fst, input int fs1, input int fs2, input int fcnt);
        vec_t v;
        v.dv = dv; v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2;
        v.dst = dst; v.wr = wr; v.ld = ld;
        v.ex_stall = FWD ? fst : nst;
        v.ex_s1    = FWD ? 2'(fs1) : 2'd0;
        v.ex_s2    = FWD ? 2'(fs2) : 2'd0;
        v.ex_cnt   = FWD ? 4'(fcnt) : 4'(ncnt);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [3:0] s1, input logic u1,
                         input logic [3:0] s2, input logic u2, input logic [3:0] dst,
                         input logic wr, input logic ld, input logic fl, input logic clr);
        dc_valid = dv; src1_idx = s1; src1_used = u1; src2_idx = s2; src2_used = u2;
        dst_idx = dst; dst_write = wr; dst_is_load = ld; flush = fl; count_clr = clr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        //               dv s1 u1 s2 u2 dst wr ld | nf:st cnt | f:st s1 s2 cnt
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 3, 1, 0,   0, 0,   0, 0, 0, 0);  // ADD r3
        vecs[2]  = mk(1, 3, 1, 0, 0, 0, 0, 0,   1, 0,   0, 1, 0, 0);  // read r3
        vecs[3]  = mk(1, 3, 1, 0, 0, 0, 0, 0,   1, 1,   0, 2, 0, 0);
        vecs[4]  = mk(1, 3, 1, 0, 0, 0, 0, 0,   1, 2,   0, 3, 0, 0);
        vecs[5]  = mk(1, 3, 1, 0, 0, 0, 0, 0,   0, 3,   0, 0, 0, 0);
        vecs[6]  = mk(1, 0, 0, 0, 0, 5, 1, 1,   0, 3,   0, 0, 0, 0);  // LOAD r5
        vecs[7]  = mk(1, 0, 0, 5, 1, 0, 0, 0,   1, 3,   1, 0, 1, 0);  // read r5
        vecs[8]  = mk(1, 0, 0, 5, 1, 0, 0, 0,   1, 4,   0, 0, 2, 1);
        vecs[9]  = mk(1, 0, 0, 5, 1, 0, 0, 0,   1, 5,   0, 0, 3, 1);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 6,   0, 0, 0, 1);
        vecs[11] = mk(1, 0, 0, 0, 0, 2, 1, 0,   0, 6,   0, 0, 0, 1);  // ADD r2
        vecs[12] = mk(1, 0, 0, 0, 0, 2, 1, 0,   0, 6,   0, 0, 0, 1);  // ADD r2
        vecs[13] = mk(1, 2, 1, 2, 1, 0, 0, 0,   1, 6,   0, 1, 1, 1);  // read r2 twice
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 7,   0, 0, 0, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 7,   0, 0, 0, 1);
        vecs[16] = mk(1, 0, 0, 0, 0, 0, 1, 0,   0, 7,   0, 0, 0, 1);  // ADD r0
        vecs[17] = mk(1, 0, 1, 0, 0, 0, 0, 0,   1, 7,   0, 1, 0, 1);  // read r0, src2 unused
        vecs[18] = mk(0, 0, 1, 0, 0, 0, 0, 0,   0, 8,   0, 2, 0, 1);  // no DC valid
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 8,   0, 0, 0, 1);

        reset = 1'b0;
        idle();
        #1;
        chk("rst_stall", 0, stall, 0);
        chk("rst_sel1", 0, sel1, 0);
        chk("rst_sel2", 0, sel2, 0);
        chk("rst_cnt", 0, cnt, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            drive(vecs[i].dv, vecs[i].s1, vecs[i].u1, vecs[i].s2, vecs[i].u2,
                  vecs[i].dst, vecs[i].wr, vecs[i].ld, 0, 0);
            #1;
            chk("stall", i, stall, vecs[i].ex_stall);
            chk("sel1", i, sel1, vecs[i].ex_s1);
            chk("sel2", i, sel2, vecs[i].ex_s2);
            chk("cnt", i, cnt, vecs[i].ex_cnt);
        end

        // Flush arriving in the middle of a load-use stall
        @(negedge clock); drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        @(negedge clock); drive(1, 5, 1, 0, 0, 9, 1, 0, 0, 0);
        #1;
        chk("flush_pre_stall", 0, stall, 1);
        #1;
        flush = 1'b1;
        #1;
        chk("flush_stall", 0, stall, 0);
        chk("flush_sel1", 0, sel1, 0);
        @(negedge clock); drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("flush_no_insert_stall", 0, stall, 0);
        chk("flush_no_insert_sel1", 0, sel1, 0);
        chk("flush_cnt", 0, cnt, CNT_AFTER_TABLE);
        repeat (3) begin @(negedge clock); idle(); end

        // Saturation: many short stalls push the 4-bit counter past 15
        for (int it = 0; it < 20; it++) begin
            @(negedge clock); drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
            repeat (3) begin @(negedge clock); drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); end
        end
        @(negedge clock); idle();
        #1;
        chk("sat_cnt", 0, cnt, 15);

        // Clear coinciding with a stall
        @(negedge clock); drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        @(negedge clock); drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("clr_stall", 0, stall, 1);
        @(negedge clock); idle();
        #1;
        chk("clr_cnt", 0, cnt, 0);
        repeat (3) begin @(negedge clock); idle(); end

        // Reset asserted between edges while stalled
        @(negedge clock); drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        @(negedge clock); drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock); drive(1, 5, 1, 0, 0, 6, 1, 1, 0, 0);
        @(negedge clock); drive(1, 5, 1, 6, 1, 0, 0, 0, 0, 0);
        #1;
        chk("rmid_pre_stall", 0, stall, 1);
        chk("rmid_pre_sel1", 0, sel1, FWD ? 3 : 0);
        chk("rmid_pre_sel2", 0, sel2, FWD ? 1 : 0);
        chk("rmid_pre_cnt", 0, cnt, FWD ? 1 : 2);
        #1;
        reset = 1'b0;
        #1;
        chk("rmid_stall", 0, stall, 0);
        chk("rmid_sel1", 0, sel1, 0);
        chk("rmid_sel2", 0, sel2, 0);
        chk("rmid_cnt", 0, cnt, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rel_stall", 0, stall, 0);
        chk("rel_sel1", 0, sel1, 0);
        chk("rel_sel2", 0, sel2, 0);
        @(negedge clock); drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        #1;
        chk("post_add_stall", 0, stall, 0);
        @(negedge clock); drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post_dep_stall", 0, stall, FWD ? 0 : 1);
        chk("post_dep_sel1", 0, sel1, FWD ? 1 : 0);
        chk("post_dep_cnt", 0, cnt, 0);
        @(negedge clock); idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_IDX_WIDTH, default 4, is the register index width.
REQ-002 Parameter PIPE_DEPTH, default 3, is the number of tracked stages after DC (EX=0, MEM=1, WB=2, ...); legal range is 2..7.
REQ-003 Parameter CNT_WIDTH, default 16, is the stall counter width.
REQ-004 Localparam SEL_WIDTH SHALL equal $clog2(PIPE_DEPTH+1).
REQ-005 Ports:
  clock  input  1  single clock; all state is rising-edge.
  reset  input  1  asynchronous, active-low.
  in_dc_valid  input  1  DC holds a valid instruction.
  in_src1_idx / in_src2_idx  input  REG_IDX_WIDTH  DC source indices.
  in_src1_used / in_src2_used  input  1  source actually read.
  in_dst_idx  input  REG_IDX_WIDTH  DC destination index.
  in_dst_write  input  1  DC instruction writes a register.
  in_dst_is_load  input  1  the write data comes from DMEM.
  in_flush  input  1  EX redirect; kills the IF and DC contents.
  in_count_clr  input  1  synchronous clear of out_stall_count.
  out_stall  output  1  hold IF/DC and insert a bubble into EX.
  out_fwd_src1_sel / out_fwd_src2_sel  output  SEL_WIDTH  0=regfile, k+1=result of tracked stage k.
  out_stall_count  output  CNT_WIDTH  saturating count of stall cycles.

Function
REQ-006 A tracker SHALL hold PIPE_DEPTH entries {valid, idx, is_load}; entry k is the instruction in stage k.
REQ-007 Each cycle: entry 0 <= DC instruction if in_dc_valid & in_dst_write & !out_stall & !in_flush, else invalid; entry k <= entry k-1.
REQ-008 A source matches entry k when the source is used, entry k is valid, and idx equals the source index; all indices, including 0, are tracked.
REQ-009 Priority SHALL go to the youngest match (lowest k).
REQ-010 out_stall and the select outputs SHALL be combinational from the tracker and DC inputs, with zero latency.
REQ-011 in_flush SHALL force out_stall=0 and both selects to 0, and no entry is inserted.
REQ-012 out_stall SHALL only be asserted while in_dc_valid=1.
REQ-013 out_stall_count SHALL increment on each cycle with out_stall=1 and SHALL hold at all-ones.
REQ-014 If in_count_clr=1 and out_stall=1 in the same cycle, the count SHALL be set to 0 (clear wins).

Reset
REQ-015 When reset=0, all entries SHALL be invalid and out_stall_count=0, asynchronously.
REQ-016 As a consequence, out_stall=0 and both selects are 0 during reset.
REQ-017 The first edge after reset deasserts SHALL follow REQ-007.

Configuration
REQ-018 With macro HAZARD_FORWARDING_EN defined:
  - the select for a matched source = k+1;
  - out_stall=1 only when the youngest match is k=0 with is_load=1 (load-use, 1 cycle).
REQ-019 Without HAZARD_FORWARDING_EN:
  - both selects are constant 0;
  - out_stall=1 whenever either source matches any entry, so the stall lasts until the writer retires from WB.

Structure
REQ-020 Shared package swt16_pkg SHALL hold the FWD_REGFILE=0 constant and the tracker entry field widths.
REQ-021 Sub-module hazard_match SHALL perform the per-source youngest-match search; it is instantiated twice.

Verification (PIPE_DEPTH=3)
REQ-022 Back-to-back ADD dependency.
  - Stimulus: ADD r3 issued; next DC reads r3 on src1.
  - FWD: stall=0, sel1=1.
  - No FWD: stall for 3 cycles, then sel1=0.
REQ-023 Load-use dependency.
  - Stimulus: LOAD r5; next DC reads r5 on src2.
  - FWD: stall=1 for exactly 1 cycle, then sel2=2.
  - out_stall_count = 1.
REQ-024 Two in-flight writers.
  - Stimulus: writers of r2 in EX and MEM; DC reads r2 on both sources.
  - Response: sel1=sel2=1.
REQ-025 Flush during load-use stall.
  - Stimulus: in_flush=1 during a load-use stall.
  - Response: stall=0 that cycle; entry 0 invalid next cycle; count unchanged.
REQ-026 Counter saturation and clear.
  - Stimulus: CNT_WIDTH=4, 20 consecutive stall cycles.
  - Response: count=15.
  - Then in_count_clr=1 with stall=1: count=0.
REQ-027 Reset mid-stall.
  - Stimulus: reset=0 mid-stall, between clock edges.
  - Response: stall, selects and count go to 0 immediately.
  - After release: no stale hazards.
